fifo: RTL and testbench
=======================

Name: fifo

Overview:
- Synchronous single-clock circular-buffer FIFO (first-word-fall-through) used as a generic queue primitive between producer/consumer logic, e.g. peripheral RX/TX buffering.
- Head entry is always presented combinationally on dout. re pops it; we pushes din.
- empty/full flags drive the handshake.

Parameters:
- XLEN, 32, data width in bits.
- LENGTH, 4, number of entries. Must be a power of two, ≥2. All LENGTH slots are usable.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- we  input  1  write enable; push din at the clock edge.
- re  input  1  read enable; pop the head entry at the clock edge.
- din  input  XLEN  write data.
- empty  output  1  high when the FIFO holds 0 entries.
- full  output  1  high when the FIFO holds LENGTH entries.
- dout  output  XLEN  current head entry, mem[front_pointer], combinational.

Behaviour:
- State:
  - Storage array mem[LENGTH] of XLEN bits.
  - front_pointer (read index) and back_pointer (write index), each $clog2(LENGTH) bits, with these exact internal names so verification can probe them hierarchically.
  - Occupancy counter, $clog2(LENGTH)+1 bits.
- Reset (synchronous, active-high): front_pointer=0, back_pointer=0, count=0, so empty=1 and full=0. mem is not reset. dout is undefined until the first write.
- empty = (count==0); full = (count==LENGTH). Both derived combinationally from registered count, so they are valid in the cycle after the causing edge.
- Write accepted when we=1 and (full=0 or re=1):
  - mem[back_pointer] <= din; back_pointer increments, wrapping LENGTH-1→0.
- Read accepted when re=1 and empty=0: front_pointer increments, wrapping.
- dout is mem[front_pointer], combinational. Zero read latency: the value is valid before the popping edge and is consumed at that edge.
- Read on empty is ignored: pointers and count unchanged, and the write path is unaffected.
- Write on full with re=0 is ignored: data is dropped, pointers and count unchanged.
- Simultaneous re and we:
  - Non-empty and not full: both proceed, count unchanged.
  - Full: both proceed (the pop frees a slot), full stays 1.
  - Empty: only the write proceeds, count becomes 1.
- count: +1 on write-only, −1 on read-only, unchanged otherwise.
- After LENGTH writes from reset, back_pointer has wrapped to 0 (equal to front_pointer) and full=1.
- Reset asserted mid-operation empties the FIFO at that edge; any simultaneous re/we is ignored.

Optional Feature:
- Macro FIFO_ERROR_FLAGS_EN.
- Defined: adds two outputs.
  - overflow (1 bit): registered, high for one cycle after an edge where we=1, full=1, re=0 (dropped write).
  - underflow (1 bit): registered, high for one cycle after an edge where re=1, empty=1.
  - Both are cleared by reset.
- Undefined: these ports and their logic do not exist. Core behaviour is identical either way.

Test Plan:
- Reset then re=1 on empty for one cycle -> empty=1, full=0, front_pointer=0, back_pointer=0.
- we=1, writes 0xdeadbeef, 0xbababebe, 0xcacacaca, 0xfeedbeef -> back_pointer steps 1,2,3,0, front_pointer stays 0, empty=0 after the first write, full=0 until the fourth write, then full=1.
- Full, we=1, din=0x00000000, re=0 -> pointers unchanged, full=1, data dropped (with FIFO_ERROR_FLAGS_EN: overflow=1 for one cycle).
- re=1, we=0 -> dout reads 0xdeadbeef, then 0xbababebe, then 0xcacacaca on successive cycles, full drops to 0 after the first pop.
- One entry left (0xfeedbeef), re=1, we=1, din=0x01010101 -> dout=0xfeedbeef before the edge, then empty=0, full=0, dout=0x01010101; one more pop -> empty=1, full=0.
- Full, re=1, we=1 -> head popped and din pushed, full stays 1; assert reset mid-stream -> next cycle empty=1, full=0, pointers 0.

Source files
------------

// File: rtl/fifo.sv
// fifo: single-clock circular-buffer FIFO with first-word-fall-through output.
//
// The head entry is always visible on dout; asserting re consumes it at the
// next rising edge, asserting we stores din at the next rising edge. All
// LENGTH slots are usable, and occupancy is tracked by a separate counter.
//
// Optional feature (macro FIFO_ERROR_FLAGS_EN): adds registered one-cycle
// overflow/underflow pulses for dropped writes and ignored reads.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous, active-high reset
//   we        - write enable, push din
//   re        - read enable, pop head entry
//   din       - write data [XLEN-1:0]
//   empty     - FIFO holds 0 entries
//   full      - FIFO holds LENGTH entries
//   dout      - current head entry (combinational)
//   overflow  - (FIFO_ERROR_FLAGS_EN) write was dropped on the last edge
//   underflow - (FIFO_ERROR_FLAGS_EN) read on empty on the last edge
module fifo #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned LENGTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic            re,
  input  logic [XLEN-1:0] din,
  output logic            empty,
  output logic            full,
  output logic [XLEN-1:0] dout
`ifdef FIFO_ERROR_FLAGS_EN
  ,
  output logic            overflow,
  output logic            underflow
`endif
);

  localparam int unsigned PtrW = $clog2(LENGTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(LENGTH);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  logic [XLEN-1:0] mem [LENGTH];

  logic [PtrW-1:0] front_pointer, front_pointer_d;
  logic [PtrW-1:0] back_pointer, back_pointer_d;
  logic [PtrW:0]   count_q, count_d;

  logic wr_en;
  logic rd_en;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FullCount);
    // A pop on a full FIFO frees a slot for the same-edge write.
    wr_en = we && (!full || re);
    rd_en = re && !empty;

    // LENGTH is a power of two, so natural pointer overflow is the wrap.
    front_pointer_d = rd_en ? front_pointer + PtrOne : front_pointer;
    back_pointer_d  = wr_en ? back_pointer + PtrOne : back_pointer;

    count_d = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      front_pointer <= '0;
      back_pointer  <= '0;
      count_q       <= '0;
    end else begin
      front_pointer <= front_pointer_d;
      back_pointer  <= back_pointer_d;
      count_q       <= count_d;
    end
  end

  // Storage is deliberately not reset; reset only gates the write.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[back_pointer] <= din;
    end
  end

  assign dout = mem[front_pointer];

`ifdef FIFO_ERROR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= we && full && !re;
      underflow_q <= re && empty;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo.sv
module tb_fifo;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned LENGTH = 4;

  logic            clk;
  logic            reset;
  logic            we;
  logic            re;
  logic [XLEN-1:0] din;
  logic            empty;
  logic            full;
  logic [XLEN-1:0] dout;
`ifdef FIFO_ERROR_FLAGS_EN
  logic            overflow;
  logic            underflow;
`endif

  fifo #(
    .XLEN  (XLEN),
    .LENGTH(LENGTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .re       (re),
    .din      (din),
    .empty    (empty),
    .full     (full),
    .dout     (dout)
`ifdef FIFO_ERROR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard: queued write data in expected pop order, plus model pointers.
  logic [XLEN-1:0] sb_q[$];
  int              m_fp = 0;
  int              m_bp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check head before the edge, update the
  // model at the edge, then check flags and pointers after it.
  task automatic cycle(input logic w, input logic r, input logic [XLEN-1:0] d);
    bit m_empty;
    bit m_full;
    bit wr_ok;
    bit rd_ok;
    m_empty = (sb_q.size() == 0);
    m_full  = (sb_q.size() == LENGTH);
    wr_ok   = w && (!m_full || r);
    rd_ok   = r && !m_empty;
    we  = w;
    re  = r;
    din = d;
    #1;
    if (rd_ok) check("dout_head", dout, sb_q[0]);
    @(posedge clk);
    #1;
    if (rd_ok) begin
      void'(sb_q.pop_front());
      m_fp = (m_fp + 1) % LENGTH;
    end
    if (wr_ok) begin
      sb_q.push_back(d);
      m_bp = (m_bp + 1) % LENGTH;
    end
    check("empty", 32'(empty), 32'(sb_q.size() == 0));
    check("full", 32'(full), 32'(sb_q.size() == LENGTH));
    check("front_pointer", 32'(dut.front_pointer), 32'(m_fp));
    check("back_pointer", 32'(dut.back_pointer), 32'(m_bp));
    if (sb_q.size() != 0) check("dout_after", dout, sb_q[0]);
`ifdef FIFO_ERROR_FLAGS_EN
    check("overflow", 32'(overflow), 32'(w && m_full && !r));
    check("underflow", 32'(underflow), 32'(r && m_empty));
`endif
    @(negedge clk);
  endtask

  task automatic do_reset(input logic w, input logic r);
    reset = 1'b1;
    we    = w;
    re    = r;
    din   = 32'h5a5a_5a5a;
    @(posedge clk);
    #1;
    sb_q.delete();
    m_fp = 0;
    m_bp = 0;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_front_pointer", 32'(dut.front_pointer), 32'd0);
    check("rst_back_pointer", 32'(dut.back_pointer), 32'd0);
`ifdef FIFO_ERROR_FLAGS_EN
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [XLEN-1:0] vec[4];
    vec[0] = 32'hdead_beef;
    vec[1] = 32'hbaba_bebe;
    vec[2] = 32'hcaca_caca;
    vec[3] = 32'hfeed_beef;
    reset = 1'b1;
    we    = 1'b0;
    re    = 1'b0;
    din   = '0;
    @(negedge clk);
    do_reset(1'b0, 1'b0);

    // Read on empty is ignored.
    cycle(1'b0, 1'b1, '0);

    // Fill to full.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, vec[i]);

    // Write on full is dropped.
    cycle(1'b1, 1'b0, 32'h0000_0000);

    // Pop three entries.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0);

    // Simultaneous read/write with one entry, then drain.
    cycle(1'b1, 1'b1, 32'h0101_0101);
    cycle(1'b0, 1'b1, '0);

    // Simultaneous read/write on empty: only the write lands.
    cycle(1'b1, 1'b1, 32'h2222_3333);
    cycle(1'b0, 1'b1, '0);

    // Refill, then read/write while full.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, vec[i] ^ 32'h0f0f_0f0f);
    cycle(1'b1, 1'b1, 32'h1234_5678);
    cycle(1'b1, 1'b1, 32'h9abc_def0);

    // Reset mid-stream with re/we asserted.
    do_reset(1'b1, 1'b1);
    cycle(1'b0, 1'b1, '0);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
